// File: rtl/baud_tick_gen.sv
// Fractional-N baud-rate generator built on a phase accumulator (NCO).
// Each enabled clock adds 'inc' to 'acc'. The carry out of the add is the
// oversample strobe. Every OVERSAMPLE-th carry is the per-bit strobe.
// A square baud clock is derived from the oversample index.
// All outputs are registered. No input reaches an output combinationally.
module baud_tick_gen #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24,
  localparam int PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             resync,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_in,
  output logic             os_tick,
  output logic             baud_tick,
  output logic [PH_W-1:0]  os_phase,
  output logic             clk_out
);

  // Rounded reset increment. It is computed in 64 bits so that
  // BAUD*OVERSAMPLE*2^ACC_W cannot overflow during elaboration.
  localparam logic [63:0] DEFAULT_INC_64 =
    (64'(BAUD) * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
  localparam logic [ACC_W-1:0] DEFAULT_INC = DEFAULT_INC_64[ACC_W-1:0];

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             phase_wrap;
  logic [ACC_W-1:0] acc_d;
  logic [PH_W-1:0]  phase_d;
  logic             os_d;
  logic             baud_d;
  logic             clk_d;

  // Increment register. A load takes effect on the following edge, so the
  // add performed on the loading edge still uses the old value.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      inc <= DEFAULT_INC;
    end else if (inc_load) begin
      inc <= inc_in;
    end
  end

  // Next-state logic. Priority is resync first, then enable.
  // With enable low, everything holds except the strobes.
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, inc};
    carry      = sum[ACC_W];
    phase_wrap = (os_phase == PH_LAST);
    acc_d      = acc;
    phase_d    = os_phase;
    os_d       = 1'b0;
    baud_d     = 1'b0;
    clk_d      = clk_out;
    if (resync) begin
      acc_d   = '0;
      phase_d = '0;
      clk_d   = 1'b0;
    end else if (enable) begin
      acc_d = sum[ACC_W-1:0];
      os_d  = carry;
      if (carry) begin
        phase_d = phase_wrap ? '0 : os_phase + PH_W'(1);
        baud_d  = phase_wrap;
      end
      clk_d = (phase_d >= PH_HALF);
    end
  end

  // Accumulator, oversample index and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      os_phase  <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      clk_out   <= 1'b0;
    end else begin
      acc       <= acc_d;
      os_phase  <= phase_d;
      os_tick   <= os_d;
      baud_tick <= baud_d;
      clk_out   <= clk_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed test of baud_tick_gen at its default parameters
// (12 MHz clock, 9600 baud, 16x oversample, 24-bit accumulator).
module tb_baud_tick_gen;

  localparam int ACC_W = 24;
  localparam int PH_W  = 4;

  // ---------------- clock / reset ----------------
  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             enable = 1'b0;
  logic             resync = 1'b0;
  logic             inc_load = 1'b0;
  logic [ACC_W-1:0] inc_in = '0;
  logic             os_tick;
  logic             baud_tick;
  logic [PH_W-1:0]  os_phase;
  logic             clk_out;

  always #5 clk_in = ~clk_in;

  baud_tick_gen dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .enable    (enable),
    .resync    (resync),
    .inc_load  (inc_load),
    .inc_in    (inc_in),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .os_phase  (os_phase),
    .clk_out   (clk_out)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] exp_q[$];  // {os_tick, baud_tick, clk_out} per edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it for sampling.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One full bit at inc=2^21 starting from acc=0, os_phase=0: os_tick every
  // 8 edges, baud_tick on edge 128, clk_out high on edges 64..127.
  task automatic run_bit(input string tag);
    logic [2:0] e;
    for (int n = 1; n <= 128; n++)
      exp_q.push_back({(n % 8) == 0, n == 128, (n >= 64) && (n < 128)});
    for (int n = 1; n <= 128; n++) begin
      step();
      e = exp_q.pop_front();
      chk({tag, "_os"},   {31'd0, os_tick},   {31'd0, e[2]});
      chk({tag, "_baud"}, {31'd0, baud_tick}, {31'd0, e[1]});
      chk({tag, "_clk"},  {31'd0, clk_out},   {31'd0, e[0]});
    end
    chk({tag, "_end_phase"}, {28'd0, os_phase}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int os_cnt, baud_cnt, bad_gap, bad_coinc, last, first, second;
    logic [PH_W-1:0] ph0;
    logic clk0;

    // Reset state
    #2;
    chk("rst_os",    {31'd0, os_tick},   32'd0);
    chk("rst_baud",  {31'd0, baud_tick}, 32'd0);
    chk("rst_phase", {28'd0, os_phase},  32'd0);
    chk("rst_clk",   {31'd0, clk_out},   32'd0);
    @(negedge clk_in);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Default rate: floor(20000*214748/2^24) = 255 os_ticks, 15 baud_ticks
    os_cnt = 0; baud_cnt = 0; bad_gap = 0; bad_coinc = 0; last = 0;
    for (int n = 1; n <= 20000; n++) begin
      step();
      if (baud_tick) baud_cnt++;
      if (baud_tick && !os_tick) bad_coinc++;
      if (os_tick) begin
        os_cnt++;
        if (last > 0 && ((n - last) < 78 || (n - last) > 79)) bad_gap++;
        last = n;
      end
    end
    chk("def_os_count",   os_cnt,    32'd255);
    chk("def_baud_count", baud_cnt,  32'd15);
    chk("def_gap",        bad_gap,   32'd0);
    chk("def_coinc",      bad_coinc, 32'd0);

    // Load 2^21 and resync, then one full bit of exact 8-edge ticks
    inc_load = 1'b1; inc_in = 24'd2097152;
    step();
    inc_load = 1'b0; resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs1_phase", {28'd0, os_phase},  32'd0);
    chk("rs1_os",    {31'd0, os_tick},   32'd0);
    chk("rs1_clk",   {31'd0, clk_out},   32'd0);
    run_bit("bit1");

    // 67 edges: 8 ticks (phase 8) plus 3/8 of the next tick accumulated
    for (int n = 0; n < 67; n++) step();
    chk("pre_pause_phase", {28'd0, os_phase}, 32'd8);
    chk("pre_pause_clk",   {31'd0, clk_out},  32'd1);
    enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      chk("pause_os",    {31'd0, os_tick},   32'd0);
      chk("pause_baud",  {31'd0, baud_tick}, 32'd0);
      chk("pause_phase", {28'd0, os_phase},  32'd8);
      chk("pause_clk",   {31'd0, clk_out},   32'd1);
    end
    enable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("resume_os_early", {31'd0, os_tick}, 32'd0);
    end
    step();
    chk("resume_os",    {31'd0, os_tick},  32'd1);
    chk("resume_phase", {28'd0, os_phase}, 32'd9);

    // Resync at os_phase 9
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs2_phase", {28'd0, os_phase},  32'd0);
    chk("rs2_clk",   {31'd0, clk_out},   32'd0);
    chk("rs2_os",    {31'd0, os_tick},   32'd0);
    chk("rs2_baud",  {31'd0, baud_tick}, 32'd0);
    run_bit("bit2");

    // inc_load and resync together: new inc 2^22 used right after
    inc_load = 1'b1; inc_in = 24'd4194304; resync = 1'b1;
    step();
    inc_load = 1'b0; resync = 1'b0;
    chk("rs3_phase", {28'd0, os_phase}, 32'd0);
    chk("rs3_os",    {31'd0, os_tick},  32'd0);
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("x4_os", {31'd0, os_tick}, {31'd0, (n % 4) == 0});
    end
    chk("x4_phase", {28'd0, os_phase}, 32'd4);

    // Asynchronous reset between edges while clk_out is high
    for (int n = 0; n < 16; n++) step();
    chk("pre_rst_clk", {31'd0, clk_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", {28'd0, os_phase},  32'd0);
    chk("arst_clk",   {31'd0, clk_out},   32'd0);
    chk("arst_os",    {31'd0, os_tick},   32'd0);
    chk("arst_baud",  {31'd0, baud_tick}, 32'd0);
    step();
    @(negedge clk_in);
    rst_n = 1'b1;

    // Default inc restored: first tick at edge 79, next 78 edges later
    first = 0; second = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (os_tick && first == 0) first = n;
      else if (os_tick && second == 0) second = n;
    end
    chk("post_rst_first", first, 32'd79);
    chk("post_rst_gap",   second - first, 32'd78);

    // inc = 0: no ticks and all outputs hold
    inc_load = 1'b1; inc_in = '0;
    step();
    inc_load = 1'b0;
    ph0 = os_phase; clk0 = clk_out;
    os_cnt = 0; baud_cnt = 0;
    for (int n = 0; n < 10000; n++) begin
      step();
      if (os_tick) os_cnt++;
      if (baud_tick) baud_cnt++;
    end
    chk("zero_os",    os_cnt,   32'd0);
    chk("zero_baud",  baud_cnt, 32'd0);
    chk("zero_phase", {28'd0, os_phase}, {28'd0, ph0});
    chk("zero_clk",   {31'd0, clk_out},  {31'd0, clk0});

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
